button_debouncer: RTL and testbench
===================================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
- REQ-001: Parameter COUNT_WIDTH, default 32, width of the stability counter.
- REQ-002: Parameter STABLE_COUNT, default 120000 (10 ms at 12 MHz), consecutive stable cycles needed to accept a new level; legal range 2..2^COUNT_WIDTH-1.
- REQ-003: clk  input  1  system clock (12 MHz on board).
- REQ-004: rst_btn  input  1  reset; asynchronous, active-low.
- REQ-005: btn_n  input  1  raw pushbutton, active-low, asynchronous to clk, may bounce.
- REQ-006: pressed  output  1  debounced level; 1 = button held.
- REQ-007: press_pulse  output  1  one-cycle strobe on each accepted press.
- REQ-008: release_pulse  output  1  one-cycle strobe on each accepted release.
- REQ-009: press_count  output  8  number of accepted presses, modulo 256.

Function
- REQ-010: btn_n SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other logic uses it.
- REQ-011: FSM states SHALL be RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND, plus counter cnt[COUNT_WIDTH-1:0].
- REQ-012: In RELEASED, sync2==0 SHALL move the FSM to PRESS_PEND with cnt=0; otherwise it SHALL stay.
- REQ-013: In PRESS_PEND, sync2==1 SHALL return the FSM to RELEASED with cnt=0 (bounce rejected, no pulse).
- REQ-014: In PRESS_PEND with sync2==0 and cnt==STABLE_COUNT-1, the FSM SHALL enter PRESSED, assert press_pulse for exactly that one cycle, and increment press_count; otherwise cnt SHALL increment.
- REQ-015: PRESSED/RELEASE_PEND SHALL mirror REQ-012..014 with the polarity inverted: sync2==1 starts RELEASE_PEND, sync2==0 aborts back to PRESSED, and commit enters RELEASED with release_pulse for one cycle.
- REQ-016: pressed SHALL be registered and equal 1 in PRESSED and RELEASE_PEND, and 0 in RELEASED and PRESS_PEND.
- REQ-017: Latency: a clean low on btn_n first sampled at edge t SHALL make pressed=1 and press_pulse=1 after edge t+STABLE_COUNT+2; release latency SHALL be identical.
- REQ-018: A glitch shorter than STABLE_COUNT cycles after synchronization SHALL produce no change on any output.
- REQ-019: press_count SHALL wrap 255 -> 0 without a stall or flag.
- REQ-020: press_pulse and release_pulse SHALL never be asserted in the same cycle, and each SHALL be high for at most one consecutive cycle.
- REQ-021: cnt SHALL never exceed STABLE_COUNT-1, and SHALL hold 0 in RELEASED and PRESSED.

Reset
- REQ-022: rst_btn low SHALL immediately, without waiting for clk, force sync1=sync2=1, FSM=RELEASED, cnt=0, pressed=0, press_pulse=0, release_pulse=0, press_count=0.
- REQ-023: A reset asserted mid-debounce or while in PRESSED SHALL discard all progress, and no pulse SHALL be emitted because of the reset.
- REQ-024: If btn_n is held low when reset deasserts, the block SHALL run a full press debounce from RELEASED and emit one press_pulse.

Verification (STABLE_COUNT=4 unless stated)
- REQ-025: Reset sequence: rst_btn=0 for 3 cycles with btn_n=0, then rst_btn=1 -> all outputs are 0 during reset; pressed=1, press_pulse=1 and press_count=1 after the 7th edge following release.
- REQ-026: Clean press: btn_n 1->0 sampled at edge t -> press_pulse is high only in the cycle after edge t+6, pressed stays 1, press_count increments by 1.
- REQ-027: Bounce: btn_n pulses low for 3 cycles, then high for 2, then low for 3, repeated 5 times -> no pulses, pressed stays 0, press_count unchanged.
- REQ-028: Release: from PRESSED, btn_n 0->1 held -> release_pulse is high for 1 cycle at the latency given in REQ-017, then pressed=0.
- REQ-029: Wrap: 256 clean press/release pairs -> press_count returns to 0, with exactly 256 press_pulses and 256 release_pulses.
- REQ-030: Async reset mid-debounce: rst_btn drops between clock edges while in PRESS_PEND with cnt=2 -> all outputs and state reach reset values before the next edge, and no pulse is emitted.

Source files
------------

// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes and debounces an active-low pushbutton into level, pulses and a press counter
module button_debouncer #(
  parameter int COUNT_WIDTH = 32,
  parameter int STABLE_COUNT = 120000
) (
  input  logic       clk,
  input  logic       rst_btn,
  input  logic       btn_n,
  output logic       pressed,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [7:0] press_count
);
  typedef enum logic [1:0] {RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND} state_t;
  localparam logic [COUNT_WIDTH-1:0] LAST = COUNT_WIDTH'(STABLE_COUNT - 1);
  state_t state, state_nxt;
  logic sync1, sync2, done, press_nxt, release_nxt;
  logic [COUNT_WIDTH-1:0] cnt, cnt_nxt;
  assign done = cnt == LAST;
  always_comb begin
    state_nxt = state;
    cnt_nxt = '0;
    press_nxt = 1'b0;
    release_nxt = 1'b0;
    case (state)
      RELEASED: state_nxt = sync2 ? RELEASED : PRESS_PEND;
      PRESS_PEND: begin
        state_nxt = sync2 ? RELEASED : done ? PRESSED : PRESS_PEND;
        cnt_nxt = (sync2 || done) ? '0 : cnt + 1'b1;
        press_nxt = !sync2 && done;
      end
      PRESSED: state_nxt = sync2 ? RELEASE_PEND : PRESSED;
      RELEASE_PEND: begin
        state_nxt = !sync2 ? PRESSED : done ? RELEASED : RELEASE_PEND;
        cnt_nxt = (!sync2 || done) ? '0 : cnt + 1'b1;
        release_nxt = sync2 && done;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      state <= RELEASED;
      cnt <= '0;
      pressed <= 1'b0;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
      press_count <= '0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      state <= state_nxt;
      cnt <= cnt_nxt;
      pressed <= state_nxt == PRESSED || state_nxt == RELEASE_PEND;
      press_pulse <= press_nxt;
      release_pulse <= release_nxt;
      press_count <= press_count + 8'(press_nxt);
    end
  end
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed and random checks of button_debouncer against a run-length reference model
module tb_button_debouncer;
  localparam int SC = 4;
  logic clk = 1'b0, rst_btn = 1'b1, btn_n = 1'b1;
  logic pressed, press_pulse, release_pulse;
  logic [7:0] press_count;
  int checks = 0, errors = 0, pp_seen = 0, rp_seen = 0, pp0, rp0, base;
  bit [1:0] hist = 2'b11;
  bit m_level = 1'b0, m_pp = 1'b0, m_rp = 1'b0;
  int m_run = 0, m_count = 0;
  button_debouncer #(.COUNT_WIDTH(8), .STABLE_COUNT(SC)) dut (
    .clk(clk),
    .rst_btn(rst_btn),
    .btn_n(btn_n),
    .pressed(pressed),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .press_count(press_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      hist <= 2'b11;
      m_level <= 1'b0;
      m_run <= 0;
      m_pp <= 1'b0;
      m_rp <= 1'b0;
      m_count <= 0;
    end else begin
      hist <= {hist[0], btn_n};
      m_pp <= 1'b0;
      m_rp <= 1'b0;
      if (!hist[1] == m_level) m_run <= 0;
      else if (m_run == SC) begin
        m_level <= !hist[1];
        m_run <= 0;
        if (hist[1]) m_rp <= 1'b1;
        else begin
          m_pp <= 1'b1;
          m_count <= (m_count + 1) % 256;
        end
      end else m_run <= m_run + 1;
    end
  end
  task automatic cmp(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic check_model();
    cmp("pressed", int'(pressed), int'(m_level));
    cmp("press_pulse", int'(press_pulse), int'(m_pp));
    cmp("release_pulse", int'(release_pulse), int'(m_rp));
    cmp("press_count", int'(press_count), m_count);
    cmp("pulse_excl", int'(press_pulse & release_pulse), 0);
    cmp("cnt_bound", int'(dut.cnt < 8'(SC)), 1);
  endtask
  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      pp_seen += int'(press_pulse);
      rp_seen += int'(release_pulse);
      check_model();
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    btn_n = 1'b0;
    #1 rst_btn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      cmp("rst_pressed", int'(pressed), 0);
      cmp("rst_pp", int'(press_pulse), 0);
      cmp("rst_rp", int'(release_pulse), 0);
      cmp("rst_count", int'(press_count), 0);
    end
    rst_btn = 1'b1;
    run(6);
    cmp("boot_early", int'(pressed), 0);
    run(1);
    cmp("boot_pp", int'(press_pulse), 1);
    cmp("boot_pressed", int'(pressed), 1);
    cmp("boot_count", int'(press_count), 1);
    run(1);
    cmp("boot_pp_once", int'(press_pulse), 0);
    btn_n = 1'b1;
    run(6);
    cmp("rel_early", int'(release_pulse), 0);
    run(1);
    cmp("rel_pulse", int'(release_pulse), 1);
    cmp("rel_pressed", int'(pressed), 0);
    run(1);
    cmp("rel_once", int'(release_pulse), 0);
    run(4);
    btn_n = 1'b0;
    run(6);
    cmp("press_early", int'(press_pulse), 0);
    run(1);
    cmp("press_pulse", int'(press_pulse), 1);
    cmp("press_count2", int'(press_count), 2);
    run(1);
    cmp("press_once", int'(press_pulse), 0);
    cmp("press_hold", int'(pressed), 1);
    run(4);
    btn_n = 1'b1;
    run(10);
    base = int'(press_count);
    pp0 = pp_seen;
    rp0 = rp_seen;
    repeat (5) begin
      btn_n = 1'b0;
      run(3);
      btn_n = 1'b1;
      run(2);
      btn_n = 1'b0;
      run(3);
      btn_n = 1'b1;
      run(2);
    end
    run(8);
    cmp("bounce_pp", pp_seen - pp0, 0);
    cmp("bounce_rp", rp_seen - rp0, 0);
    cmp("bounce_pressed", int'(pressed), 0);
    cmp("bounce_count", int'(press_count), base);
    btn_n = 1'b0;
    run(5);
    cmp("pend_cnt", int'(dut.cnt), 2);
    #2 rst_btn = 1'b0;
    #1;
    cmp("async_pressed", int'(pressed), 0);
    cmp("async_pp", int'(press_pulse), 0);
    cmp("async_count", int'(press_count), 0);
    cmp("async_cnt", int'(dut.cnt), 0);
    @(negedge clk);
    rst_btn = 1'b1;
    run(6);
    cmp("held_early", int'(pressed), 0);
    run(1);
    cmp("held_pp", int'(press_pulse), 1);
    cmp("held_count", int'(press_count), 1);
    run(3);
    pp0 = pp_seen;
    rp0 = rp_seen;
    #2 rst_btn = 1'b0;
    #1;
    cmp("rst_pressed_drop", int'(pressed), 0);
    cmp("rst_pressed_rp", int'(release_pulse), 0);
    btn_n = 1'b1;
    @(negedge clk);
    rst_btn = 1'b1;
    run(10);
    cmp("rst_no_pulse", (pp_seen - pp0) + (rp_seen - rp0), 0);
    pp0 = pp_seen;
    rp0 = rp_seen;
    repeat (256) begin
      btn_n = 1'b0;
      run(8);
      btn_n = 1'b1;
      run(8);
    end
    cmp("wrap_count", int'(press_count), 0);
    cmp("wrap_pp", pp_seen - pp0, 256);
    cmp("wrap_rp", rp_seen - rp0, 256);
    repeat (300) begin
      btn_n = 1'($urandom_range(0, 1));
      run(int'($urandom_range(1, 8)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
